lif_ring_network: RTL
=====================

Name: lif_ring_network

Overview:
- Parametrised successor to the two-neuron/one-synapse spiking top level: N clocked leaky integrate-and-fire (LIF) neurons coupled by weighted excitatory synapses.
- Neuron 0 takes an external drive current.
- Each neuron i>0 is driven by the spike of neuron i-1.
- In ring mode, neuron N-1 feeds neuron 0, forming an oscillator network.
- Adds membrane state, leak, refractory period, runtime weight, and a spike counter. None of these exist in the current neuron/synapse pair.

Parameters:
- N, 4, number of neurons (2..16).
- V_W, 8, membrane potential width.
- W_W, 4, synaptic weight width (W_W <= V_W).
- THRESH, 200, firing threshold (unsigned, < 2^V_W).
- LEAK_SHIFT, 3, leak = v >> LEAK_SHIFT per enabled cycle.
- REFRAC, 4, refractory length in enabled cycles (0..15).
- SEL_W, 2, width of vmem_sel.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  advances network state when high.
- drive  in  V_W  external current into neuron 0, unsigned.
- weight  in  W_W  synaptic weight shared by all synapses, unsigned.
- ring_mode  in  1  1 = neuron N-1 feeds neuron 0; 0 = open chain.
- vmem_sel  in  SEL_W  neuron index for vmem.
- spike  out  N  registered one-cycle spike pulses, bit i = neuron i.
- spike_count  out  16  spikes emitted by neuron N-1, saturating.
- vmem  out  V_W  membrane potential of neuron vmem_sel.

Behaviour:
- Reset (async, any time): v[i]=0, refrac[i]=0, spike=0, spike_count=0. Outputs go to 0 immediately, not on the next edge.
- enable=0: v, refrac and spike_count hold; spike register is cleared to 0 on that edge, so a spike never lasts more than one cycle.
- Per neuron i, on each enabled edge:
  - Synaptic term: syn_i = {weight, (V_W-W_W) zeros} if spike[pred(i)]==1, else 0.
    - pred(i)=i-1 for i>0.
    - pred(0)=N-1 if ring_mode, else neuron 0 receives no synaptic input.
    - spike[] here is the registered value from the previous edge, so each hop adds 1 cycle.
  - Input: in_i = syn_i + (i==0 ? drive : 0).
  - If refrac[i]!=0: refrac[i]-=1, v[i] stays 0, spike[i]<=0. All input is discarded, including coincident synaptic spikes.
  - Else:
    - sum = v - (v>>LEAK_SHIFT) + in_i, computed at V_W+2 bits, then clamped to 2^V_W-1.
    - If sum >= THRESH: spike[i]<=1, v[i]<=0, refrac[i]<=REFRAC.
    - Else: v[i]<=sum, spike[i]<=0.
- Spike latency: a threshold crossing produces spike[i] high in the cycle after the edge that computed it.
- Refractory with REFRAC=R: neuron is blind for exactly R enabled edges after the spiking edge.
- spike_count: increments by 1 on each enabled edge that sets spike[N-1]; holds at 16'hFFFF, no wrap.
- vmem: combinational mux of registered v[vmem_sel]; returns 0 if vmem_sel >= N.
- ring_mode and weight may change any cycle; they take effect on the next enabled edge.

Test Plan:
- Reset/idle:
  - Stimulus: reset pulse mid-run, then enable=1, drive=0, weight=0.
  - Required: spike=0, all vmem=0, spike_count=0 for 20 cycles; outputs clear without waiting for a clock edge.
- Integration and leak (defaults, drive=50, weight=0, ring_mode=0):
  - Required vmem[0] sequence: 50, 94, 133, 167, 197.
  - Required spike[0]=1 after the 6th edge, vmem[0]=0.
  - Required: 4 refractory edges at 0, then 50 again; firing period 10 edges.
- Chain propagation (drive=50, weight=15, syn=240):
  - Required: spike[1], spike[2] and spike[3] high one cycle apart after spike[0] (edges 7, 8, 9).
  - Required: spike_count=1 after edge 9.
- Ring with refractory block (same stimulus, ring_mode=1):
  - Required: spike[3] at edge 9 is ignored by neuron 0, which is refractory through edge 10.
  - Required: period stays 10.
  - Then REFRAC=2 build: neuron 0 receives 240 from spike[3] at edge 10 and fires again at edge 10.
  - Required: self-sustained oscillation continues with drive=0.
- Saturation (THRESH=255 build, drive=200, weight=0):
  - Required: edge 2 sum 375 clamps to 255; spike[0]=1 at edge 2; no wrap to a small v.
- Enable freeze:
  - Stimulus: drop enable for 5 cycles when vmem[0]=133.
  - Required: vmem[0] stays 133, refrac holds, spike=0; on resume next value is 167.
  - spike_count forced to 0xFFFE (forced via bench): required 0xFFFF after the next spike, then holds 0xFFFF.

Source files
------------

// File: rtl/lif_ring_network.sv
// N leaky integrate-and-fire neurons coupled by excitatory synapses of one shared weight,
// forming an open chain or, in ring mode, an oscillating loop.
module lif_ring_network #(
  parameter int N          = 4,
  parameter int V_W        = 8,
  parameter int W_W        = 4,
  parameter int THRESH     = 200,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 4,
  parameter int SEL_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [V_W-1:0]   drive,
  input  logic [W_W-1:0]   weight,
  input  logic             ring_mode,
  input  logic [SEL_W-1:0] vmem_sel,
  output logic [N-1:0]     spike,
  output logic [15:0]      spike_count,
  output logic [V_W-1:0]   vmem
);

  localparam int SUM_W = V_W + 2;
  localparam logic [SUM_W-1:0] V_MAX      = {2'b00, {V_W{1'b1}}};
  localparam logic [SUM_W-1:0] THRESH_EXT = SUM_W'(THRESH);

  logic [V_W-1:0] syn;
  logic [N-1:0]   pred_spike;
  logic [N-1:0]   fire_now;
  logic [V_W-1:0] v_all [N];

  // The weight lands in the top bits of the membrane range.
  assign syn        = V_W'(weight) << (V_W - W_W);
  assign pred_spike = {spike[N-2:0], ring_mode & spike[N-1]};

  for (genvar i = 0; i < N; i++) begin : g_neuron
    logic [V_W-1:0]   v;
    logic [3:0]       refrac;
    logic             spk;
    logic [SUM_W-1:0] in_sum;
    logic [SUM_W-1:0] sum;

    always_comb begin
      in_sum = pred_spike[i] ? SUM_W'(syn) : '0;
      if (i == 0) in_sum = in_sum + SUM_W'(drive);
      sum = SUM_W'(v) - SUM_W'(v >> LEAK_SHIFT) + in_sum;
      if (sum > V_MAX) sum = V_MAX;
    end

    assign fire_now[i] = (refrac == 4'd0) && (sum >= THRESH_EXT);
    assign v_all[i]    = v;
    assign spike[i]    = spk;

    // Refractory neurons discard all input, even a coincident synaptic spike.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v      <= '0;
        refrac <= '0;
        spk    <= 1'b0;
      end else if (!enable) begin
        spk <= 1'b0;
      end else if (refrac != 4'd0) begin
        refrac <= refrac - 4'd1;
        v      <= '0;
        spk    <= 1'b0;
      end else if (fire_now[i]) begin
        spk    <= 1'b1;
        v      <= '0;
        refrac <= 4'(REFRAC);
      end else begin
        spk <= 1'b0;
        v   <= sum[V_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      spike_count <= '0;
    else if (enable && fire_now[N-1] && spike_count != 16'hFFFF)
      spike_count <= spike_count + 16'd1;
  end

  always_comb begin
    vmem = '0;
    for (int k = 0; k < N; k++)
      if (vmem_sel == SEL_W'(k)) vmem = v_all[k];
  end

endmodule
